// File: rtl/mic_pkg.sv
// mic_pkg: shared sizes and types for mic_sample_framer (FRAMER_DC_REMOVE_EN selects DC removal)
package mic_pkg;
  localparam int N_SAMPLES = 16;
  localparam int SAMPLE_W = 16;
  localparam int OUT_W = 32;
  localparam int LOG2_N = $clog2(N_SAMPLES);
  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [OUT_W-1:0] word_t;
  typedef word_t frame_t [N_SAMPLES];
  typedef logic [LOG2_N-1:0] idx_t;
  typedef enum logic {EMPTY, HELD} state_t;
endpackage

// File: rtl/framer_bank.sv
// framer_bank: one N-entry sample register bank with indexed write and parallel read
module framer_bank
  import mic_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_we,
  input  idx_t    i_idx,
  input  sample_t i_data,
  output sample_t o_data [N_SAMPLES]
);
  sample_t r_mem [N_SAMPLES];
  // clear on reset so no stale samples survive; write one entry per qualified sample
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < N_SAMPLES; i++) r_mem[i] <= '0;
    else if (i_we)
      r_mem[i_idx] <= i_data;
  assign o_data = r_mem;
endmodule

// File: rtl/mic_sample_framer.sv
// mic_sample_framer: ping-pong framer of mic samples with valid/ready hand-off (FRAMER_DC_REMOVE_EN adds DC removal)
module mic_sample_framer
  import mic_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] mic_stream,
  input  logic                frame_ready,
  input  logic                clear_overrun,
  output logic                frame_valid,
  output frame_t              frame_samples,
  output logic [7:0]          frame_count,
  output logic                overrun
);
  state_t     r_state;
  state_t     w_state_nx;
  idx_t       r_idx;
  logic       r_bank_sel;
  logic       r_overrun;
  logic [7:0] r_count;
  logic       w_done;
  logic       w_swap;
  logic       w_drop;
  sample_t    w_bank0 [N_SAMPLES];
  sample_t    w_bank1 [N_SAMPLES];
  sample_t    w_rd [N_SAMPLES];

  assign w_done = sample_valid && (r_idx == idx_t'(N_SAMPLES - 1));

  // read-bank state: a completed frame is taken only if the read bank is empty or being emptied now
  always_comb begin
    w_state_nx = r_state;
    w_swap = 1'b0;
    w_drop = 1'b0;
    if (w_done && r_state == HELD && !frame_ready)
      w_drop = 1'b1;
    else if (w_done) begin
      w_swap = 1'b1;
      w_state_nx = HELD;
    end else if (r_state == HELD && frame_ready)
      w_state_nx = EMPTY;
  end

  // fill index, bank select, hand-off count and sticky overrun (a new drop beats a clear)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= EMPTY;
      r_idx <= '0;
      r_bank_sel <= 1'b0;
      r_count <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_idx <= sample_valid ? r_idx + idx_t'(1) : r_idx;
      r_bank_sel <= r_bank_sel ^ w_swap;
      r_count <= r_count + {7'd0, w_swap};
      r_overrun <= w_drop | (r_overrun & ~clear_overrun);
    end

  framer_bank u_bank0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_we   (sample_valid && !r_bank_sel),
    .i_idx  (r_idx),
    .i_data (mic_stream),
    .o_data (w_bank0)
  );

  framer_bank u_bank1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_we   (sample_valid && r_bank_sel),
    .i_idx  (r_idx),
    .i_data (mic_stream),
    .o_data (w_bank1)
  );

  // the read bank is always the one not being filled
  always_comb
    for (int i = 0; i < N_SAMPLES; i++) w_rd[i] = r_bank_sel ? w_bank0[i] : w_bank1[i];

`ifdef FRAMER_DC_REMOVE_EN
  localparam int SUM_W = SAMPLE_W + LOG2_N;
  logic [SUM_W-1:0] r_sum;
  logic [SUM_W-1:0] w_sum_nx;
  sample_t          r_mean;

  assign w_sum_nx = r_sum + SUM_W'(mic_stream);

  // running frame sum; its floor mean is latched only when the frame is actually handed off
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sum <= '0;
      r_mean <= '0;
    end else if (sample_valid) begin
      r_sum <= w_done ? '0 : w_sum_nx;
      if (w_swap) r_mean <= sample_t'(w_sum_nx >> LOG2_N);
    end

  // mean-removed samples, wrapping naturally into two's complement
  always_comb
    for (int i = 0; i < N_SAMPLES; i++) frame_samples[i] = word_t'(w_rd[i]) - word_t'(r_mean);
`else
  // raw samples zero-extended to the output word
  always_comb
    for (int i = 0; i < N_SAMPLES; i++) frame_samples[i] = word_t'(w_rd[i]);
`endif

  assign frame_valid = (r_state == HELD);
  assign frame_count = r_count;
  assign overrun = r_overrun;
endmodule
